// File: rtl/shift_seq_pkg.sv
// Shared types and default sizing for the shift-sequence controller.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/shift_seq_ctrl_bit_counter.sv
// Synchronous up-counter with clear/enable and a terminal flag at WIDTH-1.
module bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Clear wins over enable so an abort or accept always restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == TERM_CNT);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Parallel-in/serial-out shift sequencer: accepts a word on start, shifts it
// out MSB-first one bit per clock, then pulses done for one cycle.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             ser_o,
  output logic             shift_en_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o
);

  state_e           state_d;
  state_e           state_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shreg_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_term;

  bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .clear_i (cnt_clr),
    .en_i    (cnt_en),
    .cnt_o   (cnt),
    .term_o  (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          shreg_d = data_i;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Abort takes precedence over the last-bit check.
        if (abort_i) begin
          shreg_d = '0;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_en  = 1'b1;
          if (cnt_term) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  assign ready_o    = (state_q == ST_IDLE);
  assign busy_o     = (state_q == ST_SHIFT);
  assign shift_en_o = (state_q == ST_SHIFT);
  assign ser_o      = (state_q == ST_SHIFT) & shreg_q[WIDTH-1];
  assign done_o     = (state_q == ST_DONE);
  assign cnt_o      = (state_q == ST_SHIFT) ? cnt : '0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomised and directed bench for shift_seq_ctrl against a cycle-offset model.
module tb_shift_seq_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic          start;
  logic          abort;
  logic [W-1:0]  data;
  logic          ready_o, busy_o, ser_o, shift_en_o, done_o;
  logic [CW-1:0] cnt_o;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i     (clk),
    .nreset_i  (nreset),
    .start_i   (start),
    .data_i    (data),
    .abort_i   (abort),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .ser_o     (ser_o),
    .shift_en_o(shift_en_o),
    .done_o    (done_o),
    .cnt_o     (cnt_o)
  );

  // Model: t = cycles since the accepting edge (0 = idle, 1..W = bit t-1 on line, W+1 = done).
  int           t = 0;
  logic [W-1:0] word = '0;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      t <= 0;
    end else if (t == 0) begin
      if (start) begin
        t    <= 1;
        word <= data;
      end
    end else if (t <= W) begin
      t <= abort ? 0 : t + 1;
    end else begin
      t <= 0;
    end
  end

  // Capture of the serial stream, done pulses and inter-word gap.
  int           clr_seq = 0;
  int           seen_seq = 0;
  int           cyc = 0;
  logic [31:0]  stream = '0;
  int           nbits = 0;
  int           ndone = 0;
  int           last_busy = -1;
  int           gap = -1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr_seq != seen_seq) begin
      seen_seq  <= clr_seq;
      stream    <= '0;
      nbits     <= 0;
      ndone     <= 0;
      last_busy <= -1;
      gap       <= -1;
    end else begin
      if (busy_o) begin
        stream <= {stream[30:0], ser_o};
        nbits  <= nbits + 1;
        if (last_busy >= 0 && last_busy != cyc - 1) gap <= cyc - last_busy - 1;
        last_busy <= cyc;
      end
      if (done_o) ndone <= ndone + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 'h%0h required 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    start = 1'b1;
    data  = d;
    step(1);
    start = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, ready_o, busy_o, shift_en_o, ser_o, done_o, cnt_o};
  endfunction

  function automatic logic [31:0] model_outs();
    logic          b;
    logic          s;
    logic [CW-1:0] c;
    b = (t >= 1 && t <= W);
    s = b ? word[W-t] : 1'b0;
    c = b ? CW'(t - 1) : '0;
    return {23'd0, (t == 0), b, b, s, (t == W + 1), c};
  endfunction

  localparam logic [31:0] RST_OUTS = {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

  logic [W-1:0] rnd_word;

  initial begin
    nreset = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    data   = '0;

    fork
      forever begin
        @(negedge clk);
        chk("model_outputs", outs(), model_outs());
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", outs(), RST_OUTS);
    nreset = 1'b1;
    step(1);
    chk("reset_released", outs(), RST_OUTS);

    // Basic A5 transfer with cycle-pinned literals.
    clr_seq++;
    send(8'hA5);
    chk("a5_c1_ser_cnt", {ser_o, cnt_o}, {1'b1, 4'd0});
    step(3);
    chk("a5_c4_ser_cnt", {ser_o, cnt_o}, {1'b0, 4'd3});
    step(5);
    chk("a5_c9_done", {done_o, busy_o, ready_o}, 3'b100);
    step(1);
    chk("a5_c10_ready", {done_o, ready_o}, 2'b01);
    step(2);
    chk("a5_stream", stream[7:0], 8'hA5);
    chk("a5_nbits", nbits, 8);
    chk("a5_ndone", ndone, 1);

    // Start held during a transfer is ignored.
    clr_seq++;
    send(8'h3C);
    step(1);
    start = 1'b1;
    data  = 8'hFF;
    step(4);
    start = 1'b0;
    step(8);
    chk("ign_stream", stream[7:0], 8'h3C);
    chk("ign_nbits", nbits, 8);
    chk("ign_ndone", ndone, 1);

    // Abort in cycle 4.
    clr_seq++;
    send(8'hF0);
    step(3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_c5_idle", {ready_o, busy_o, ser_o, cnt_o}, {3'b100, 4'd0});
    step(3);
    chk("abort_ndone", ndone, 0);
    chk("abort_nbits", nbits, 4);
    chk("abort_partial", stream[3:0], 4'hF);
    clr_seq++;
    send(8'h81);
    step(11);
    chk("post_abort_stream", stream[7:0], 8'h81);
    chk("post_abort_ndone", ndone, 1);

    // Continuous start: two words with a DONE + IDLE gap.
    clr_seq++;
    start = 1'b1;
    data  = 8'h01;
    step(1);
    data = 8'h80;
    step(10);
    start = 1'b0;
    step(10);
    chk("cont_stream", stream[15:0], 16'h0180);
    chk("cont_nbits", nbits, 16);
    chk("cont_ndone", ndone, 2);
    chk("cont_gap", gap, 2);

    // Asynchronous reset between edges in cycle 5.
    clr_seq++;
    rnd_word = W'($urandom);
    send(rnd_word);
    step(4);
    #2;
    nreset = 1'b0;
    #1;
    chk("async_rst_outs", outs(), RST_OUTS);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    step(12);
    chk("async_rst_ndone", ndone, 0);
    clr_seq++;
    send(8'h55);
    step(11);
    chk("post_rst_stream", stream[7:0], 8'h55);
    chk("post_rst_ndone", ndone, 1);

    // Random traffic, checked every cycle by the model compare.
    repeat (400) begin
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 7) == 0);
      data  = W'($urandom);
      step(1);
    end
    start = 1'b0;
    abort = 1'b0;
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
